// File: rtl/match_frame_counter.sv
// rtl/match_frame_counter.sv - counts "101" detector matches per frame and reports them over a valid/ready channel
// Optional threshold alarm on the reported count: define MATCH_ALARM_EN.
module match_frame_counter #(
  parameter int FRAME_LEN = 16,
  parameter int CNT_W     = 5,
  parameter int THRESH    = 3
) (
  input  logic             clk,
  input  logic             areset,
  input  logic             bit_vld,
  input  logic             match,
  input  logic             frame_start,
  output logic             rpt_valid,
  input  logic             rpt_ready,
  output logic [CNT_W-1:0] rpt_count,
  output logic             rpt_ovf,
  output logic             rpt_drop,
  output logic             alarm
);

  localparam int IDX_W = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_LEN - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  typedef enum logic {IDLE, COUNT} state_t;

  state_t            state_q, state_d;
  logic [IDX_W-1:0]  bit_idx_q, bit_idx_d;
  logic [CNT_W-1:0]  match_cnt_q, match_cnt_d;
  logic              ovf_q, ovf_d;
  logic              rpt_valid_q, rpt_valid_d;
  logic [CNT_W-1:0]  rpt_count_q, rpt_count_d;
  logic              rpt_ovf_q, rpt_ovf_d;
  logic              rpt_drop_q, rpt_drop_d;

  logic              last_bit;
  logic              rpt_load;
  logic [CNT_W-1:0]  fin_cnt;
  logic              fin_ovf;

  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      state_q     <= IDLE;
      bit_idx_q   <= '0;
      match_cnt_q <= '0;
      ovf_q       <= 1'b0;
      rpt_valid_q <= 1'b0;
      rpt_count_q <= '0;
      rpt_ovf_q   <= 1'b0;
      rpt_drop_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      bit_idx_q   <= bit_idx_d;
      match_cnt_q <= match_cnt_d;
      ovf_q       <= ovf_d;
      rpt_valid_q <= rpt_valid_d;
      rpt_count_q <= rpt_count_d;
      rpt_ovf_q   <= rpt_ovf_d;
      rpt_drop_q  <= rpt_drop_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    bit_idx_d   = bit_idx_q;
    match_cnt_d = match_cnt_q;
    ovf_d       = ovf_q;

    // Running count including this cycle's bit, saturating at CNT_MAX.
    fin_cnt = match_cnt_q;
    fin_ovf = ovf_q;
    if (match) begin
      if (match_cnt_q == CNT_MAX) fin_ovf = 1'b1;
      else                        fin_cnt = match_cnt_q + CNT_W'(1);
    end

    last_bit = (state_q == COUNT) && bit_vld && (bit_idx_q == LAST_IDX);

    if (last_bit) begin
      // The closing bit belongs to the ending frame; a same-cycle start opens an empty frame.
      state_d     = frame_start ? COUNT : IDLE;
      bit_idx_d   = '0;
      match_cnt_d = '0;
      ovf_d       = 1'b0;
    end else if (frame_start) begin
      state_d     = COUNT;
      bit_idx_d   = bit_vld ? IDX_W'(1) : '0;
      match_cnt_d = (bit_vld && match) ? CNT_W'(1) : '0;
      ovf_d       = 1'b0;
    end else if (state_q == COUNT && bit_vld) begin
      bit_idx_d   = bit_idx_q + IDX_W'(1);
      match_cnt_d = fin_cnt;
      ovf_d       = fin_ovf;
    end

    rpt_load    = last_bit && (!rpt_valid_q || rpt_ready);
    rpt_valid_d = rpt_load || (rpt_valid_q && !rpt_ready);
    rpt_count_d = rpt_load ? fin_cnt : rpt_count_q;
    rpt_ovf_d   = rpt_load ? fin_ovf : rpt_ovf_q;
    rpt_drop_d  = rpt_drop_q || (last_bit && rpt_valid_q && !rpt_ready);
  end

  assign rpt_valid = rpt_valid_q;
  assign rpt_count = rpt_count_q;
  assign rpt_ovf   = rpt_ovf_q;
  assign rpt_drop  = rpt_drop_q;

`ifdef MATCH_ALARM_EN
  logic alarm_q, alarm_d;

  always_comb begin
    alarm_d = alarm_q;
    if (rpt_load)                      alarm_d = (int'(fin_cnt) >= THRESH);
    else if (rpt_valid_q && rpt_ready) alarm_d = 1'b0;
  end

  always_ff @(posedge clk or posedge areset) begin
    if (areset) alarm_q <= 1'b0;
    else        alarm_q <= alarm_d;
  end

  assign alarm = alarm_q;
`else
  localparam int unused_thresh = THRESH;
  assign alarm = 1'b0;
`endif

endmodule
